mac_accum_stage: RTL and testbench

MAC_ACCUM_STAGE -- requirements
Module: mac_accum_stage

---
 rtl/mac_pkg.sv | 12 +
 rtl/sat_add_acc.sv | 20 ++
 rtl/mac_accum_stage.sv | 118 +++++++++++
 tb/tb_mac_accum_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants for the MAC accumulate stage:
// FSM state encoding and default datapath widths.
package mac_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

endpackage

// File: rtl/sat_add_acc.sv
// Saturating accumulate adder: acc + prod,
// clamps to all ones and flags a carry-out.
module sat_add_acc #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [15:0]      prod,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  always_comb begin
    full = {1'b0, acc} + {{(ACC_W-15){1'b0}}, prod};
    ovf  = full[ACC_W];
    sum  = ovf ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_accum_stage.sv
// Frame accumulator: sums product beats until last,
// then holds the saturated sum until downstream takes it.
module mac_accum_stage
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [15:0]      prod_data,
  input  logic             prod_last,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic [CNT_W-1:0] acc_cnt,
  output logic             acc_ovf
);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rdy_q, rdy_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             beat;
  logic [1:0]       nxt_st;
  logic [CNT_W-1:0] cnt_inc;

  sat_add_acc #(
    .ACC_W(ACC_W)
  ) u_add (
    .acc (acc_q),
    .prod(prod_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // rdy_q keeps prod_ready low until the first edge out of reset
  assign prod_ready = rdy_q && (state_q != S_HOLD);
  assign acc_valid  = (state_q == S_HOLD);
  assign acc_data   = acc_q;
  assign acc_cnt    = cnt_q;
  assign acc_ovf    = ovf_q;

  assign beat    = prod_valid && prod_ready;
  assign nxt_st  = prod_last ? S_HOLD : S_ACCUM;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rdy_d   = 1'b1;
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (beat) begin
            state_d = nxt_st;
            acc_d   = {{(ACC_W-16){1'b0}}, prod_data};
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            ovf_d   = 1'b0;
          end
        end
        (state_q == S_ACCUM): begin
          if (beat) begin
            state_d = nxt_st;
            acc_d   = ovf_q ? '1 : add_sum;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_q || add_ovf;
          end
        end
        (state_q == S_HOLD): begin
          if (acc_ready) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_mac_accum_stage.sv
// Self-checking bench for mac_accum_stage: directed
// scenarios plus random frames against a sum model.
module tb_mac_accum_stage;

  localparam int ACC_W = 24;
  localparam int CNT_W = 8;
  localparam longint AMAX = (64'd1 << ACC_W) - 1;
  localparam int CMAX = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             prod_valid = 1'b0;
  logic             prod_ready;
  logic [15:0]      prod_data = '0;
  logic             prod_last = 1'b0;
  logic             acc_valid;
  logic             acc_ready = 1'b0;
  logic [ACC_W-1:0] acc_data;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_ovf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mac_accum_stage #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .prod_data (prod_data),
    .prod_last (prod_last),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_data  (acc_data),
    .acc_cnt   (acc_cnt),
    .acc_ovf   (acc_ovf)
  );

  // Expected result of a frame: plain sum, clamped, count clamped.
  function automatic void model(input int unsigned q[$],
                                output logic [ACC_W-1:0] s,
                                output logic [CNT_W-1:0] c,
                                output logic o);
    longint t = 0;
    foreach (q[i]) t += longint'(q[i]);
    o = (t > AMAX);
    s = o ? ACC_W'(AMAX) : ACC_W'(t);
    c = (q.size() > CMAX) ? CNT_W'(CMAX) : CNT_W'(q.size());
  endfunction

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic put_beat(input logic [15:0] d, input logic l,
                          output bit ok);
    int n = 0;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = l;
    while (!prod_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = prod_ready;
    @(negedge clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({acc_valid, prod_ready, acc_data, acc_cnt, acc_ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outs: v=%b r=%b d=%0h c=%0d o=%b want all 0",
               acc_valid, prod_ready, acc_data, acc_cnt, acc_ovf);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (prod_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_rdy_early: prod_ready=%b want 0", prod_ready);
    end
    @(negedge clk);
    total++;
    if (prod_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_rdy_rise: prod_ready=%b want 1", prod_ready);
    end
  endtask

  task automatic test_basic;
    int unsigned q[$];
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    logic eo;
    bit ok, all_ok;
    all_ok = 1'b1;
    acc_ready = 1'b1;
    q = '{100, 200, 300};
    foreach (q[i]) begin
      put_beat(16'(q[i]), i == 2, ok);
      all_ok &= ok;
    end
    model(q, es, ec, eo);
    total++;
    if (!all_ok || {acc_valid, acc_data, acc_cnt, acc_ovf} !== {1'b1, es, ec, eo}) begin
      bad++;
      $display("FAIL basic_sum: v=%b d=%0d c=%0d o=%b want v=1 d=%0d c=%0d o=%b",
               acc_valid, acc_data, acc_cnt, acc_ovf, es, ec, eo);
    end
    @(negedge clk);
    total++;
    if (acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_one_cycle: acc_valid=%b want 0", acc_valid);
    end
  endtask

  task automatic test_single;
    int unsigned q[$];
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    logic eo;
    bit ok;
    acc_ready = 1'b1;
    q = '{32'hFFFF};
    put_beat(16'hFFFF, 1'b1, ok);
    model(q, es, ec, eo);
    total++;
    if (!ok || {acc_valid, acc_data, acc_cnt, acc_ovf} !== {1'b1, es, ec, eo}) begin
      bad++;
      $display("FAIL single_beat: v=%b d=%0h c=%0d o=%b want v=1 d=%0h c=%0d o=%b",
               acc_valid, acc_data, acc_cnt, acc_ovf, es, ec, eo);
    end
    @(negedge clk);
  endtask

  task automatic test_saturate;
    int unsigned q[$];
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    logic eo;
    bit ok, all_ok;
    all_ok = 1'b1;
    acc_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      q.push_back(32'hFFFF);
      put_beat(16'hFFFF, i == 256, ok);
      all_ok &= ok;
    end
    model(q, es, ec, eo);
    total++;
    if (!all_ok || {acc_valid, acc_data, acc_cnt, acc_ovf} !== {1'b1, es, ec, eo}) begin
      bad++;
      $display("FAIL saturate: v=%b d=%0h c=%0d o=%b want v=1 d=%0h c=%0d o=%b",
               acc_valid, acc_data, acc_cnt, acc_ovf, es, ec, eo);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok1, ok2;
    acc_ready = 1'b0;
    put_beat(16'd5, 1'b0, ok1);
    put_beat(16'd7, 1'b1, ok2);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (!ok1 || !ok2 ||
          {acc_valid, prod_ready, acc_data} !== {1'b1, 1'b0, ACC_W'(12)}) begin
        bad++;
        $display("FAIL hold_stable[%0d]: v=%b r=%b d=%0d want v=1 r=0 d=12",
                 i, acc_valid, prod_ready, acc_data);
      end
      @(negedge clk);
    end
    acc_ready  = 1'b1;
    prod_valid = 1'b1;
    prod_data  = 16'd9;
    prod_last  = 1'b1;
    @(negedge clk);
    total++;
    if ({acc_valid, prod_ready, acc_cnt} !== {1'b0, 1'b1, CNT_W'(0)}) begin
      bad++;
      $display("FAIL bubble: v=%b r=%b c=%0d want v=0 r=1 c=0",
               acc_valid, prod_ready, acc_cnt);
    end
    @(negedge clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    total++;
    if ({acc_valid, acc_data, acc_cnt} !== {1'b1, ACC_W'(9), CNT_W'(1)}) begin
      bad++;
      $display("FAIL after_bubble: v=%b d=%0d c=%0d want v=1 d=9 c=1",
               acc_valid, acc_data, acc_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_clr;
    bit ok1, ok2, ok3;
    acc_ready = 1'b1;
    put_beat(16'd10, 1'b0, ok1);
    put_beat(16'd20, 1'b0, ok2);
    prod_valid = 1'b1;
    prod_data  = 16'd30;
    prod_last  = 1'b1;
    clr        = 1'b1;
    @(negedge clk);
    clr        = 1'b0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    total++;
    if (!ok1 || !ok2 ||
        {acc_valid, prod_ready, acc_data, acc_cnt} !== {1'b0, 1'b1, ACC_W'(0), CNT_W'(0)}) begin
      bad++;
      $display("FAIL clr_abort: v=%b r=%b d=%0d c=%0d want v=0 r=1 d=0 c=0",
               acc_valid, prod_ready, acc_data, acc_cnt);
    end
    repeat (2) @(negedge clk);
    total++;
    if (acc_valid !== 1'b0) begin
      bad++;
      $display("FAIL clr_no_result: acc_valid=%b want 0", acc_valid);
    end
    put_beat(16'd4, 1'b1, ok3);
    total++;
    if (!ok3 || {acc_valid, acc_data, acc_cnt, acc_ovf} !== {1'b1, ACC_W'(4), CNT_W'(1), 1'b0}) begin
      bad++;
      $display("FAIL clr_next_frame: v=%b d=%0d c=%0d o=%b want v=1 d=4 c=1 o=0",
               acc_valid, acc_data, acc_cnt, acc_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_hold;
    bit ok;
    acc_ready = 1'b0;
    put_beat(16'd77, 1'b1, ok);
    total++;
    if (!ok || acc_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsthold_enter: acc_valid=%b want 1", acc_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({acc_valid, prod_ready, acc_data, acc_cnt, acc_ovf} !== '0) begin
      bad++;
      $display("FAIL rsthold_async: v=%b r=%b d=%0d c=%0d o=%b want all 0",
               acc_valid, prod_ready, acc_data, acc_cnt, acc_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({prod_ready, acc_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rsthold_release: r=%b v=%b want r=1 v=0",
               prod_ready, acc_valid);
    end
  endtask

  task automatic test_random;
    int unsigned q[$];
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    logic eo;
    bit ok, all_ok;
    int len;
    logic [15:0] d;
    for (int f = 0; f < 24; f++) begin
      q.delete();
      all_ok = 1'b1;
      acc_ready = 1'b0;
      len = (f % 8 == 7) ? int'($urandom_range(256, 300)) : int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        d = (len > 100) ? 16'($urandom_range(16'hF000, 16'hFFFF))
                        : 16'($urandom_range(0, 16'hFFFF));
        q.push_back(32'(d));
        if (b > 0 && $urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 2)) @(negedge clk);
        put_beat(d, b == len - 1, ok);
        all_ok &= ok;
      end
      model(q, es, ec, eo);
      total++;
      if (!all_ok || {acc_valid, acc_data, acc_cnt, acc_ovf} !== {1'b1, es, ec, eo}) begin
        bad++;
        $display("FAIL rand_frame[%0d]: v=%b d=%0h c=%0d o=%b want v=1 d=%0h c=%0d o=%b",
                 f, acc_valid, acc_data, acc_cnt, acc_ovf, es, ec, eo);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      total++;
      if ({acc_valid, prod_ready, acc_data, acc_cnt, acc_ovf} !== {1'b1, 1'b0, es, ec, eo}) begin
        bad++;
        $display("FAIL rand_hold[%0d]: v=%b r=%b d=%0h c=%0d o=%b want v=1 r=0 d=%0h c=%0d o=%b",
                 f, acc_valid, prod_ready, acc_data, acc_cnt, acc_ovf, es, ec, eo);
      end
      acc_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({acc_valid, acc_data, acc_cnt, acc_ovf} !== '0) begin
        bad++;
        $display("FAIL rand_drain[%0d]: v=%b d=%0h c=%0d o=%b want all 0",
                 f, acc_valid, acc_data, acc_cnt, acc_ovf);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single;
    test_saturate;
    test_backpressure;
    test_clr;
    test_reset_hold;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
